led_pattern_engine: RTL and testbench



---
 rtl/led_pattern_engine.sv | 151 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: switch-controlled moving LED patterns on a WIDTH-bit bank.
// Single clock; step timing comes from an internal period counter acting as a
// clock enable. LED and step are registered.
module led_pattern_engine #(
  parameter int WIDTH        = 16,
  parameter int MAX_CNT_DEST = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       SW,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] LED,
  output logic             step
);

  localparam int CNT_W = $clog2(2 * MAX_CNT_DEST);

  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(2 * MAX_CNT_DEST - 1);
  localparam logic [CNT_W-1:0] MED_M1  = CNT_W'(MAX_CNT_DEST - 1);
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'((2 * MAX_CNT_DEST) / 5 - 1);

  localparam logic [1:0] SW_PAUSE = 2'b00;
  localparam logic [1:0] SW_SLOW  = 2'b01;
  localparam logic [1:0] SW_MED   = 2'b10;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,  // toward MSB
    DIR_DOWN = 1'b1   // toward LSB
  } dir_e;

  logic [WIDTH-1:0] led_q, led_d, led_adv;
  dir_e             dir_q, dir_d, dir_adv;
  mode_e            mode_q, mode_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_m1;
  logic             step_q, step_d;

  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    logic [WIDTH-1:0] s;
    case (m)
      MODE_ROR:  s = {1'b1, {(WIDTH-1){1'b0}}};
      MODE_FILL: s = '0;
      default:   s = {{(WIDTH-1){1'b0}}, 1'b1};
    endcase
    return s;
  endfunction

  // State register: synchronous reset reseeds from the MODE sampled this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= seed(MODE);
      mode_q <= mode_e'(MODE);
      sel_q  <= SW;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      mode_q <= mode_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  // Period terminal count for the currently latched rate
  always_comb begin
    case (sel_q)
      SW_SLOW: period_m1 = SLOW_M1;
      SW_MED:  period_m1 = MED_M1;
      default: period_m1 = FAST_M1;
    endcase
  end

  // One pattern advance for the current mode and direction
  always_comb begin
    led_adv = led_q;
    dir_adv = dir_q;
    case (mode_q)
      MODE_ROL: led_adv = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      MODE_ROR: led_adv = {led_q[0], led_q[WIDTH-1:1]};
      MODE_BOUNCE: begin
        // Turning at an endpoint shifts away immediately, so endpoints never dwell twice
        if (dir_q == DIR_UP && led_q[WIDTH-1]) begin
          dir_adv = DIR_DOWN;
          led_adv = led_q >> 1;
        end else if (dir_q == DIR_DOWN && led_q[0]) begin
          dir_adv = DIR_UP;
          led_adv = led_q << 1;
        end else if (dir_q == DIR_UP) begin
          led_adv = led_q << 1;
        end else begin
          led_adv = led_q >> 1;
        end
      end
      MODE_FILL: begin
        if (dir_q == DIR_UP) begin
          led_adv = {led_q[WIDTH-2:0], 1'b1};
          if (led_adv == '1) dir_adv = DIR_DOWN;
        end else begin
          led_adv = led_q >> 1;
          if (led_adv == '0) dir_adv = DIR_UP;
        end
      end
    endcase
  end

  // Next state: mode change > rate change > pause > terminal count > count
  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    if (MODE != mode_q) begin
      led_d  = seed(MODE);
      dir_d  = DIR_UP;
      mode_d = mode_e'(MODE);
      sel_d  = SW;
      cnt_d  = '0;
    end else if (SW != sel_q) begin
      sel_d = SW;
      cnt_d = '0;
    end else if (sel_q == SW_PAUSE) begin
      cnt_d = '0;
    end else if (cnt_q == period_m1) begin
      cnt_d  = '0;
      led_d  = led_adv;
      dir_d  = dir_adv;
      step_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs come straight from registers
  always_comb begin
    LED  = led_q;
    step = step_q;
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed self-checking bench, WIDTH=4, MAX_CNT_DEST=5
// (periods 10 / 5 / 2 clocks). Inputs change and outputs are sampled on negedge.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic [1:0] mode;
  logic [3:0] led;
  logic       step;

  int n_cmp  = 0;
  int n_fail = 0;

  led_pattern_engine #(.WIDTH(4), .MAX_CNT_DEST(5)) dut (
    .clk  (clk),
    .rst  (rst),
    .SW   (sw),
    .MODE (mode),
    .LED  (led),
    .step (step)
  );

  always #5 clk = ~clk;

  // Count negedges until step is seen (bounded; 0 means it never came)
  task automatic wait_step(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 200 && cycles == 0; i++) begin
      @(negedge clk);
      if (step === 1'b1) cycles = i;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 2'b01; mode = 2'b01;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (led !== 4'b1000 || step !== 1'b0) begin n_fail++; $display("FAIL reset_ror_seed: got led=%b step=%b expected led=1000 step=0", led, step); end
    mode = 2'b00;
    @(negedge clk);
    n_cmp++; if (led !== 4'b0001 || step !== 1'b0) begin n_fail++; $display("FAIL reset_rol_seed: got led=%b step=%b expected led=0001 step=0", led, step); end
    rst = 1'b0;
  endtask

  task automatic test_rotate_left();
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int c, e;
    for (int k = 0; k < 4; k++) begin
      wait_step(c);
      e = (k == 0) ? 10 : 9;
      n_cmp++; if (c != e) begin n_fail++; $display("FAIL rol_spacing[%0d]: got %0d clocks expected %0d", k, c, e); end
      n_cmp++; if (led !== seq[k]) begin n_fail++; $display("FAIL rol_value[%0d]: got %b expected %b", k, led, seq[k]); end
      @(negedge clk);
      n_cmp++; if (step !== 1'b0 || led !== seq[k]) begin n_fail++; $display("FAIL rol_pulse[%0d]: got led=%b step=%b expected led=%b step=0", k, led, step, seq[k]); end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    int c;
    mode = 2'b10; sw = 2'b11;
    @(negedge clk);
    n_cmp++; if (led !== 4'b0001 || step !== 1'b0) begin n_fail++; $display("FAIL bounce_seed: got led=%b step=%b expected led=0001 step=0", led, step); end
    for (int k = 0; k < 7; k++) begin
      wait_step(c);
      n_cmp++; if (c != 2) begin n_fail++; $display("FAIL bounce_spacing[%0d]: got %0d clocks expected 2", k, c); end
      n_cmp++; if (led !== seq[k]) begin n_fail++; $display("FAIL bounce_value[%0d]: got %b expected %b", k, led, seq[k]); end
    end
  endtask

  task automatic test_rotate_right();
    logic [3:0] seq [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    int c;
    mode = 2'b01;
    @(negedge clk);
    n_cmp++; if (led !== 4'b1000 || step !== 1'b0) begin n_fail++; $display("FAIL ror_seed: got led=%b step=%b expected led=1000 step=0", led, step); end
    for (int k = 0; k < 4; k++) begin
      wait_step(c);
      n_cmp++; if (c != 2) begin n_fail++; $display("FAIL ror_spacing[%0d]: got %0d clocks expected 2", k, c); end
      n_cmp++; if (led !== seq[k]) begin n_fail++; $display("FAIL ror_value[%0d]: got %b expected %b", k, led, seq[k]); end
    end
  endtask

  task automatic test_fill_drain();
    logic [3:0] seq [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111,
                            4'b0011, 4'b0001, 4'b0000, 4'b0001};
    int c;
    mode = 2'b11; sw = 2'b10;
    @(negedge clk);
    n_cmp++; if (led !== 4'b0000 || step !== 1'b0) begin n_fail++; $display("FAIL fill_seed: got led=%b step=%b expected led=0000 step=0", led, step); end
    for (int k = 0; k < 9; k++) begin
      wait_step(c);
      n_cmp++; if (c != 5) begin n_fail++; $display("FAIL fill_spacing[%0d]: got %0d clocks expected 5", k, c); end
      n_cmp++; if (led !== seq[k]) begin n_fail++; $display("FAIL fill_value[%0d]: got %b expected %b", k, led, seq[k]); end
    end
  endtask

  task automatic test_pause_rate();
    int c;
    int bad = 0;
    mode = 2'b00; sw = 2'b01;
    @(negedge clk);
    n_cmp++; if (led !== 4'b0001) begin n_fail++; $display("FAIL pause_seed: got %b expected 0001", led); end
    wait_step(c);
    wait_step(c);
    n_cmp++; if (c != 10 || led !== 4'b0100) begin n_fail++; $display("FAIL pause_setup: got led=%b after %0d clocks expected led=0100 after 10", led, c); end
    sw = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (led !== 4'b0100 || step !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0 || led !== 4'b0100) begin n_fail++; $display("FAIL pause_hold: got %0d bad cycles, led=%b expected 0 bad cycles, led=0100", bad, led); end
    sw = 2'b10;
    @(negedge clk);
    n_cmp++; if (led !== 4'b0100 || step !== 1'b0) begin n_fail++; $display("FAIL rate_change_edge: got led=%b step=%b expected led=0100 step=0", led, step); end
    wait_step(c);
    n_cmp++; if (c != 5) begin n_fail++; $display("FAIL rate_first_step: got %0d clocks expected 5", c); end
    n_cmp++; if (led !== 4'b1000) begin n_fail++; $display("FAIL rate_first_value: got %b expected 1000", led); end
  endtask

  // Bounce to 0100 at SW=10, then switch to fill/drain with cnt==3
  task automatic test_mode_change(input logic [1:0] new_sw, input int p);
    int c;
    mode = 2'b10;
    @(negedge clk);
    n_cmp++; if (led !== 4'b0001) begin n_fail++; $display("FAIL mc_bounce_seed: got %b expected 0001", led); end
    wait_step(c);
    wait_step(c);
    n_cmp++; if (led !== 4'b0100 || c != 5) begin n_fail++; $display("FAIL mc_setup: got led=%b after %0d clocks expected led=0100 after 5", led, c); end
    repeat (3) @(negedge clk);
    mode = 2'b11; sw = new_sw;
    @(negedge clk);
    n_cmp++; if (led !== 4'b0000 || step !== 1'b0) begin n_fail++; $display("FAIL mc_reseed(sw=%b): got led=%b step=%b expected led=0000 step=0", new_sw, led, step); end
    wait_step(c);
    n_cmp++; if (c != p) begin n_fail++; $display("FAIL mc_first_step(sw=%b): got %0d clocks expected %0d", new_sw, c, p); end
    n_cmp++; if (led !== 4'b0001) begin n_fail++; $display("FAIL mc_first_value(sw=%b): got %b expected 0001", new_sw, led); end
  endtask

  task automatic test_reset_mid();
    int c;
    mode = 2'b01; sw = 2'b10;
    @(negedge clk);
    n_cmp++; if (led !== 4'b1000) begin n_fail++; $display("FAIL rm_seed: got %b expected 1000", led); end
    wait_step(c);
    n_cmp++; if (led !== 4'b0100 || c != 5) begin n_fail++; $display("FAIL rm_setup: got led=%b after %0d clocks expected led=0100 after 5", led, c); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (led !== 4'b1000 || step !== 1'b0) begin n_fail++; $display("FAIL rm_reset_value: got led=%b step=%b expected led=1000 step=0", led, step); end
    rst = 1'b0;
    wait_step(c);
    n_cmp++; if (c != 5) begin n_fail++; $display("FAIL rm_first_step: got %0d clocks expected 5", c); end
    n_cmp++; if (led !== 4'b0100) begin n_fail++; $display("FAIL rm_first_value: got %b expected 0100", led); end
  endtask

  initial begin
    test_reset();
    test_rotate_left();
    test_bounce();
    test_rotate_right();
    test_fill_drain();
    test_pause_rate();
    test_mode_change(2'b10, 5);
    test_mode_change(2'b11, 2);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
